// File: rtl/ahb_sram.sv
// AHB-Lite zero-wait-state slave in front of a word-wide SRAM used as on-chip scratch memory.
// Writes commit at the end of the data phase; a read of a word still in its write data phase gets the write forwarded.

module ahb_sram_mem #(
    parameter int unsigned depth = 1024,
    parameter int unsigned abit  = 10,
    parameter int unsigned dw    = 32
) (
    input  logic            clk,
    input  logic            we,
    input  logic [dw/8-1:0] be,
    input  logic [abit-1:0] waddr,
    input  logic [dw-1:0]   wdata,
    input  logic [abit-1:0] raddr,
    output logic [dw-1:0]   rdata
);

    localparam int unsigned n_lanes = dw / 8;

    logic [dw-1:0] mem [depth];

    // Lane-masked write. The array has no reset, so its contents survive rstn.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < int'(n_lanes); i++) begin
                if (be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

module ahb_sram #(
    parameter int unsigned mem_depth = 1024,
    parameter int unsigned mem_abit  = 10,
    parameter int unsigned mem_dw    = 32
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                hsel,
    input  logic [mem_abit+1:0] haddr,
    input  logic [2:0]          hburst,
    input  logic [1:0]          htrans,
    input  logic [2:0]          hsize,
    input  logic [3:0]          hprot,
    input  logic                hwrite,
    input  logic [mem_dw-1:0]   hwdata,
    input  logic                hready,
    output logic                hreadyout,
    output logic [31:0]         hrdata,
    output logic [1:0]          hresp
);

    localparam int unsigned n_lanes = 4;

    logic                a_valid;
    logic [mem_abit-1:0] a_idx;
    logic                d_valid;
    logic                d_write;
    logic [mem_abit-1:0] d_idx;
    logic [1:0]          d_lo;
    logic [2:0]          d_size;
    logic [n_lanes-1:0]  d_be;
    logic                wr_en;
    logic                fwd;
    logic [mem_dw-1:0]   mem_rdata;
    logic [mem_dw-1:0]   rd_merge;
    logic                unused_ok;

    // Indices beyond mem_depth fold back into the array.
    function automatic logic [mem_abit-1:0] wrap_idx(input logic [mem_abit-1:0] idx);
        if (32'(idx) < mem_depth) return idx;
        return mem_abit'(32'(idx) % mem_depth);
    endfunction

    assign a_valid   = hsel & hready & htrans[1];
    assign a_idx     = wrap_idx(haddr[mem_abit+1:2]);
    assign hreadyout = 1'b1;
    assign hresp     = 2'b00;
    assign unused_ok = ^{hburst, hprot};

    // Address-phase capture; a reset drops any write waiting for its data phase.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            d_valid <= 1'b0;
            d_write <= 1'b0;
            d_idx   <= '0;
            d_lo    <= 2'b00;
            d_size  <= 3'b000;
        end else if (hready) begin
            d_valid <= a_valid;
            if (a_valid) begin
                d_write <= hwrite;
                d_idx   <= a_idx;
                d_lo    <= haddr[1:0];
                d_size  <= hsize;
            end
        end
    end

    always_comb begin
        d_be = '0;
        if (d_size >= 3'd2)   d_be = 4'b1111;
        else if (d_size[0])   d_be = d_lo[1] ? 4'b1100 : 4'b0011;
        else                  d_be = 4'(4'b0001 << d_lo);
    end

    assign wr_en = d_valid & d_write;
    assign fwd   = wr_en & (d_idx == a_idx);

    // Same-word read behind a write: take the enabled lanes from hwdata.
    always_comb begin
        rd_merge = mem_rdata;
        for (int i = 0; i < int'(n_lanes); i++) begin
            if (fwd & d_be[i]) rd_merge[8*i +: 8] = hwdata[8*i +: 8];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                   hrdata <= '0;
        else if (a_valid & ~hwrite)  hrdata <= rd_merge;
    end

    ahb_sram_mem #(
        .depth (mem_depth),
        .abit  (mem_abit),
        .dw    (mem_dw)
    ) u_mem (
        .clk   (clk),
        .we    (wr_en),
        .be    (d_be),
        .waddr (d_idx),
        .wdata (hwdata),
        .raddr (a_idx),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_ahb_sram.sv
// Directed bench for ahb_sram: a byte-lane memory model feeds a queue of expected read words,
// popped one cycle after each read address phase.

module tb_ahb_sram;

    logic        clk = 1'b0;
    logic        rstn;
    logic        hsel;
    logic [11:0] haddr;
    logic [2:0]  hburst;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic [3:0]  hprot;
    logic        hwrite;
    logic [31:0] hwdata;
    logic        hready;
    logic        hreadyout;
    logic [31:0] hrdata;
    logic [1:0]  hresp;

    always #5 clk = ~clk;

    ahb_sram u_ahb_sram (
        .clk       (clk),
        .rstn      (rstn),
        .hsel      (hsel),
        .haddr     (haddr),
        .hburst    (hburst),
        .htrans    (htrans),
        .hsize     (hsize),
        .hprot     (hprot),
        .hwrite    (hwrite),
        .hwdata    (hwdata),
        .hready    (hready),
        .hreadyout (hreadyout),
        .hrdata    (hrdata),
        .hresp     (hresp)
    );

    logic [31:0] model [1024];
    logic [31:0] exp_q [$];
    int          passed = 0;
    int          total  = 0;
    logic        prev_wr;
    logic [9:0]  prev_idx;
    logic [1:0]  prev_lo;
    logic [2:0]  prev_size;
    logic [31:0] prev_wdata;
    logic [31:0] last_rd;

    function automatic logic [3:0] lanes(input logic [2:0] size, input logic [1:0] lo);
        if (size >= 3'd2) return 4'b1111;
        if (size == 3'd1) return lo[1] ? 4'b1100 : 4'b0011;
        case (lo)
            2'd0:    return 4'b0001;
            2'd1:    return 4'b0010;
            2'd2:    return 4'b0100;
            default: return 4'b1000;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // One bus cycle: drive this address phase plus the previous transfer's write data.
    task automatic phase(input logic sel, input logic [1:0] trans, input logic wr,
                         input logic [11:0] addr, input logic [2:0] size, input logic [31:0] wdata);
        logic       valid;
        logic [3:0] be;
        hsel   = sel;
        htrans = trans;
        hwrite = wr;
        haddr  = addr;
        hsize  = size;
        hburst = 3'($urandom);
        hprot  = 4'($urandom);
        hwdata = prev_wdata;
        if (prev_wr) begin
            be = lanes(prev_size, prev_lo);
            for (int i = 0; i < 4; i++)
                if (be[i]) model[prev_idx][8*i +: 8] = prev_wdata[8*i +: 8];
        end
        valid = sel & trans[1];
        if (valid & !wr) exp_q.push_back(model[addr[11:2]]);
        @(posedge clk);
        #1;
        chk("hreadyout", 32'(hreadyout), 32'd1);
        chk("hresp", 32'(hresp), 32'd0);
        if (valid & !wr) begin
            last_rd = exp_q.pop_front();
            chk("hrdata", hrdata, last_rd);
        end else begin
            chk("hrdata_hold", hrdata, last_rd);
        end
        prev_wr    = valid & wr;
        prev_idx   = addr[11:2];
        prev_lo    = addr[1:0];
        prev_size  = size;
        prev_wdata = wdata;
    endtask

    initial begin
        rstn       = 1'b0;
        hsel       = 1'b0;
        haddr      = '0;
        hburst     = '0;
        htrans     = 2'b00;
        hsize      = '0;
        hprot      = '0;
        hwrite     = 1'b0;
        hwdata     = '0;
        hready     = 1'b1;
        prev_wr    = 1'b0;
        prev_idx   = '0;
        prev_lo    = '0;
        prev_size  = '0;
        prev_wdata = '0;
        last_rd    = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_hrdata", hrdata, 32'd0);
        chk("rst_hreadyout", 32'(hreadyout), 32'd1);
        chk("rst_hresp", 32'(hresp), 32'd0);
        rstn = 1'b1;

        // Sequential full-word writes (hsize=3 acts as a word), then flush the last data phase.
        for (int i = 0; i < 32; i++) phase(1'b1, 2'b10, 1'b1, 12'(i*4), 3'd3, 32'(i+1));
        phase(1'b1, 2'b00, 1'b0, 12'h000, 3'd2, 32'd0);
        for (int i = 0; i < 32; i++) chk("mem_seq", u_ahb_sram.u_mem.mem[i], 32'(i+1));

        for (int i = 0; i < 32; i++) phase(1'b1, 2'b10, 1'b0, 12'(i*4), 3'd2, 32'd0);

        // Read directly behind a write to the same word.
        phase(1'b1, 2'b10, 1'b1, 12'h010, 3'd2, 32'hDEADBEEF);
        phase(1'b1, 2'b10, 1'b0, 12'h010, 3'd2, 32'd0);
        chk("hazard", hrdata, 32'hDEADBEEF);

        // Word, byte, halfword, then a read forwarding only the halfword lanes.
        phase(1'b1, 2'b10, 1'b1, 12'h020, 3'd2, 32'h11223344);
        phase(1'b1, 2'b11, 1'b1, 12'h023, 3'd0, 32'hAA000000);
        phase(1'b1, 2'b11, 1'b1, 12'h020, 3'd1, 32'h00005566);
        phase(1'b1, 2'b10, 1'b0, 12'h020, 3'd2, 32'd0);
        chk("subword", hrdata, 32'hAA225566);
        chk("subword_mem", u_ahb_sram.u_mem.mem[8], 32'hAA225566);

        // IDLE, deselected and BUSY writes must not touch memory.
        phase(1'b1, 2'b00, 1'b1, 12'h030, 3'd2, 32'hFFFFFFFF);
        phase(1'b0, 2'b10, 1'b1, 12'h030, 3'd2, 32'hFFFFFFFF);
        phase(1'b1, 2'b01, 1'b1, 12'h030, 3'd2, 32'hFFFFFFFF);
        phase(1'b1, 2'b00, 1'b0, 12'h000, 3'd2, 32'd0);
        chk("noop_mem", u_ahb_sram.u_mem.mem[12], 32'd13);

        // Reset during a write data phase drops that write.
        phase(1'b1, 2'b10, 1'b1, 12'h040, 3'd2, 32'h0BADF00D);
        phase(1'b1, 2'b10, 1'b1, 12'h040, 3'd2, 32'h12345678);
        hsel   = 1'b0;
        htrans = 2'b00;
        hwdata = prev_wdata;
        rstn   = 1'b0;
        #1;
        chk("rst_mid_hrdata", hrdata, 32'd0);
        @(posedge clk);
        #1;
        rstn    = 1'b1;
        prev_wr = 1'b0;
        last_rd = 32'd0;
        chk("rst_drop", u_ahb_sram.u_mem.mem[16], 32'h0BADF00D);

        phase(1'b1, 2'b10, 1'b0, 12'h040, 3'd2, 32'd0);
        phase(1'b1, 2'b10, 1'b0, 12'h000, 3'd2, 32'd0);
        phase(1'b1, 2'b10, 1'b0, 12'h07C, 3'd2, 32'd0);
        phase(1'b1, 2'b10, 1'b0, 12'h010, 3'd2, 32'd0);
        phase(1'b1, 2'b10, 1'b0, 12'h020, 3'd0, 32'd0);
        phase(1'b1, 2'b00, 1'b0, 12'h000, 3'd2, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
